sha1_stream: RTL

Parametrised multi-block SHA-1 compression engine; successor to the single-block sha1core.
- Accepts 32-bit message words (already padded by the host), 16 per block.
- Chains intermediate hash across blocks until the host restarts the message.
- Computes ROUNDS_PER_CYCLE rounds per clock, trading area for latency.
- Sits between a word-stream source (bus bridge or FIFO) and digest consumers.

---
 rtl/sha1_pkg.sv | 58 +++++
 rtl/sha1_round.sv | 19 +
 rtl/sha1_stream.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, state types and round helper functions.
package sha1_pkg;

    localparam logic [31:0] H0_INIT = 32'h67452301;
    localparam logic [31:0] H1_INIT = 32'hefcdab89;
    localparam logic [31:0] H2_INIT = 32'h98badcfe;
    localparam logic [31:0] H3_INIT = 32'h10325476;
    localparam logic [31:0] H4_INIT = 32'hc3d2e1f0;

    localparam logic [31:0] K0 = 32'h5a827999;
    localparam logic [31:0] K1 = 32'h6ed9eba1;
    localparam logic [31:0] K2 = 32'h8f1bbcdc;
    localparam logic [31:0] K3 = 32'hca62c1d6;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_state_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        ADD  = 2'd2
    } state_t;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        rol = (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20) begin
            sha1_f = (b & c) | (~b & d);
        end else if (t < 7'd40) begin
            sha1_f = b ^ c ^ d;
        end else if (t < 7'd60) begin
            sha1_f = (b & c) | (b & d) | (c & d);
        end else begin
            sha1_f = b ^ c ^ d;
        end
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        if (t < 7'd20) begin
            sha1_k = K0;
        end else if (t < 7'd40) begin
            sha1_k = K1;
        end else if (t < 7'd60) begin
            sha1_k = K2;
        end else begin
            sha1_k = K3;
        end
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: working state plus W[t] in, next working state out.
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_state_t state_i,
    input  logic [31:0] w_i,
    input  logic [6:0]  t_i,
    output sha1_state_t state_o
);

    logic [31:0] temp_s;

    assign temp_s = rol(state_i.a, 5'd5) + sha1_f(t_i, state_i.b, state_i.c, state_i.d)
                  + state_i.e + sha1_k(t_i) + w_i;

    assign state_o = '{a: temp_s, b: state_i.a, c: rol(state_i.b, 5'd30),
                       d: state_i.c, e: state_i.d};

endmodule

// File: rtl/sha1_stream.sv
// Multi-block SHA-1 engine computing ROUNDS_PER_CYCLE rounds per clock, chaining h0..h4 across blocks.
// Build option SHA1_STREAM_BYTESWAP_EN byte-reverses each accepted word for little-endian hosts.
module sha1_stream
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        init,
    input  logic        wr,
    input  logic [31:0] data,
    output logic [31:0] h0,
    output logic [31:0] h1,
    output logic [31:0] h2,
    output logic [31:0] h3,
    output logic [31:0] h4,
    output logic        busy,
    output logic        done
);

    localparam int         RUN_CYCLES = 80 / ROUNDS_PER_CYCLE;
    localparam logic [6:0] LAST_BASE  = 7'((RUN_CYCLES - 1) * ROUNDS_PER_CYCLE);
    localparam logic [6:0] RPC_STEP   = 7'(ROUNDS_PER_CYCLE);
    localparam bit         RPC_OK     = (ROUNDS_PER_CYCLE == 1)  || (ROUNDS_PER_CYCLE == 2)  ||
                                        (ROUNDS_PER_CYCLE == 4)  || (ROUNDS_PER_CYCLE == 5)  ||
                                        (ROUNDS_PER_CYCLE == 8)  || (ROUNDS_PER_CYCLE == 10) ||
                                        (ROUNDS_PER_CYCLE == 16) || (ROUNDS_PER_CYCLE == 20);

    if (!RPC_OK) begin : g_bad_rpc
        $error("sha1_stream: ROUNDS_PER_CYCLE must divide 80 and be at most 20");
    end

    state_t      state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [3:0]  cnt_q, widx_s;
    logic [6:0]  rnd_q;
    logic [31:0] h_q [5];
    sha1_state_t abcde_q, run_st_s;
    logic [31:0] w_q [16];
    logic [31:0] wwin_s [16];
    logic [31:0] wt_s [ROUNDS_PER_CYCLE];
    logic [31:0] data_s;
    logic        last_word_s;

`ifdef SHA1_STREAM_BYTESWAP_EN
    assign data_s = {data[7:0], data[15:8], data[23:16], data[31:24]};
`else
    assign data_s = data;
`endif

    // init restarts the block, so a simultaneous write lands in W[0]
    assign widx_s      = init ? 4'd0 : cnt_q;
    assign last_word_s = wr && (widx_s == 4'd15);

    // Expand the circular schedule across this cycle's rounds, letting later rounds see earlier results
    always_comb begin
        logic [31:0] win [16];
        logic [6:0]  t;
        logic [3:0]  idx;
        win = w_q;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            t   = rnd_q + 7'(i);
            idx = t[3:0];
            if (t < 7'd16) begin
                wt_s[i] = win[idx];
            end else begin
                wt_s[i] = rol(win[idx + 4'd13] ^ win[idx + 4'd8] ^ win[idx + 4'd2] ^ win[idx], 5'd1);
            end
            win[idx] = wt_s[i];
        end
        wwin_s = win;
    end

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        sha1_state_t st_in_s, st_out_s;
        if (g == 0) begin : g_first
            assign st_in_s = abcde_q;
        end else begin : g_next
            assign st_in_s = g_rnd[g-1].st_out_s;
        end
        sha1_round u_round (
            .state_i (st_in_s),
            .w_i     (wt_s[g]),
            .t_i     (rnd_q + 7'(g)),
            .state_o (st_out_s)
        );
    end
    assign run_st_s = g_rnd[ROUNDS_PER_CYCLE-1].st_out_s;

    // State register with registered busy/done flags
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= LOAD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (last_word_s) state_d = RUN;
                else             state_d = LOAD;
            end
            RUN: begin
                if (rnd_q == LAST_BASE) state_d = ADD;
                else                    state_d = RUN;
            end
            ADD:     state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Flag values for the upcoming state
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            LOAD: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            RUN:  busy_d = 1'b1;
            ADD: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Message buffer, working state and chaining value
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            h_q[0]  <= H0_INIT;
            h_q[1]  <= H1_INIT;
            h_q[2]  <= H2_INIT;
            h_q[3]  <= H3_INIT;
            h_q[4]  <= H4_INIT;
            cnt_q   <= 4'd0;
            rnd_q   <= 7'd0;
            abcde_q <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (init) begin
                        h_q[0] <= H0_INIT;
                        h_q[1] <= H1_INIT;
                        h_q[2] <= H2_INIT;
                        h_q[3] <= H3_INIT;
                        h_q[4] <= H4_INIT;
                    end
                    if (wr) w_q[widx_s] <= data_s;
                    cnt_q <= wr ? widx_s + 4'd1 : widx_s;
                    if (last_word_s) begin
                        abcde_q <= '{a: h_q[0], b: h_q[1], c: h_q[2], d: h_q[3], e: h_q[4]};
                        rnd_q   <= 7'd0;
                    end
                end
                RUN: begin
                    abcde_q <= run_st_s;
                    w_q     <= wwin_s;
                    rnd_q   <= rnd_q + RPC_STEP;
                end
                ADD: begin
                    h_q[0] <= h_q[0] + abcde_q.a;
                    h_q[1] <= h_q[1] + abcde_q.b;
                    h_q[2] <= h_q[2] + abcde_q.c;
                    h_q[3] <= h_q[3] + abcde_q.d;
                    h_q[4] <= h_q[4] + abcde_q.e;
                end
                default: begin
                    cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign h0   = h_q[0];
    assign h1   = h_q[1];
    assign h2   = h_q[2];
    assign h3   = h_q[3];
    assign h4   = h_q[4];
    assign busy = busy_q;
    assign done = done_q;

endmodule
